// File: rtl/register.sv
// Clock-enabled storage register with synchronous reset to a parameterised value.
// Building block for pipeline registers, the PC and general-purpose storage.
module register #(
  parameter int                    ELEM_WIDTH  = 32,
  parameter logic [ELEM_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [ELEM_WIDTH-1:0] d_i,
  output logic [ELEM_WIDTH-1:0] q_o
);

  if (ELEM_WIDTH < 1) begin : g_bad_width
    $fatal(1, "register: ELEM_WIDTH must be >= 1");
  end

  // Reset wins over enable, so a write pending at the reset edge is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= RESET_VALUE;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: tb/tb_register.sv
// Directed and random checks of register: a 32-bit default instance and an
// 8-bit instance with a non-zero reset value, with scoreboard queues of expected q.
module tb_register;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_a, en_a;
  logic [31:0] d_a, q_a;
  logic        rst_b, en_b;
  logic [7:0]  d_b, q_b;

  register #(.ELEM_WIDTH(32)) u_reg_a (
    .clk_i(clk_i), .rst_i(rst_a), .en_i(en_a), .d_i(d_a), .q_o(q_a)
  );

  register #(.ELEM_WIDTH(8), .RESET_VALUE(8'h3C)) u_reg_b (
    .clk_i(clk_i), .rst_i(rst_b), .en_i(en_b), .d_i(d_b), .q_o(q_b)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_a_q[$];
  logic [7:0]  exp_b_q[$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle, push the expected result, then compare after the edge.
  task automatic step_a(input logic rst, input logic en, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
    @(negedge clk_i);
    rst_a = rst; en_a = en; d_a = d;
    exp_a_q.push_back(exp);
    @(posedge clk_i);
    #1;
    if (exp_a_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      check32(tag, q_a, exp_a_q.pop_front());
    end
  endtask

  task automatic step_b(input logic rst, input logic en, input logic [7:0] d,
                        input logic [7:0] exp, input string tag);
    @(negedge clk_i);
    rst_b = rst; en_b = en; d_b = d;
    exp_b_q.push_back(exp);
    @(posedge clk_i);
    #1;
    if (exp_b_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      check8(tag, q_b, exp_b_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] ref_q;
    logic        r_en;
    logic [31:0] r_d;

    rst_a = 1'b1; en_a = 1'b1; d_a = 32'hDEAD_BEEF;
    rst_b = 1'b0; en_b = 1'b0; d_b = 8'h00;

    step_a(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, "reset_edge1");
    step_a(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, "reset_edge2");

    // Inputs change between edges must not reach q_o before the next edge.
    @(negedge clk_i);
    rst_a = 1'b0; en_a = 1'b1; d_a = 32'h1234_5678;
    #1;
    check32("write_before_edge", q_a, 32'h0000_0000);
    @(posedge clk_i);
    #1;
    check32("write_after_edge", q_a, 32'h1234_5678);

    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, "hold");
    end

    step_a(1'b0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "load_a5");
    step_a(1'b1, 1'b1, 32'h5A5A_5A5A, 32'h0000_0000, "reset_priority");
    step_a(1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, "post_reset_write");

    // Reset raised between edges takes effect only at the next edge.
    step_a(1'b0, 1'b1, 32'hCAFE_0001, 32'hCAFE_0001, "stream_w1");
    @(negedge clk_i);
    rst_a = 1'b1; en_a = 1'b1; d_a = 32'hCAFE_0002;
    #1;
    check32("reset_before_edge", q_a, 32'hCAFE_0001);
    @(posedge clk_i);
    #1;
    check32("midstream_reset", q_a, 32'h0000_0000);
    step_a(1'b0, 1'b1, 32'hCAFE_0003, 32'hCAFE_0003, "stream_w3");

    step_b(1'b1, 1'b0, 8'h00, 8'h3C, "b_reset_value");
    step_b(1'b0, 1'b1, 8'hFF, 8'hFF, "b_write_ff");
    step_b(1'b0, 1'b0, 8'h11, 8'hFF, "b_hold");
    step_b(1'b1, 1'b1, 8'hAA, 8'h3C, "b_reset_priority");
    step_b(1'b0, 1'b1, 8'h5A, 8'h5A, "b_write_5a");

    ref_q = 32'hCAFE_0003;
    for (int i = 0; i < 1000; i++) begin
      r_en = 1'($urandom_range(0, 1));
      r_d  = $urandom;
      if (r_en) ref_q = r_d;
      step_a(1'b0, r_en, r_d, ref_q, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register.md
Name: register

Overview:
- Parameterised, clock-enabled storage register, the basic state element of the processor datapath.
- Used for pipeline registers, PC and general-purpose storage.
- Captures d_i on a rising clock edge when enabled, and holds its value otherwise.
- Synchronous reset loads a parameterised reset value.

Parameters:
- ELEM_WIDTH, 32, data width in bits; must be >= 1.
- RESET_VALUE, '0 (ELEM_WIDTH bits), value loaded into q_o by reset.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- en_i  input  1  write enable; active-high.
- d_i  input  ELEM_WIDTH  data to capture.
- q_o  output  ELEM_WIDTH  stored value; driven directly from the storage flops.

Behaviour:
- All updates occur on the rising edge of clk_i only. There is no asynchronous path and no combinational path from any input to q_o.
- Priority at each rising edge:
  - rst_i=1: q_o <= RESET_VALUE. This applies regardless of en_i and d_i.
  - else en_i=1: q_o <= d_i, using the value sampled at that edge.
  - else: q_o holds its value.
- Latency: one cycle. Data sampled at edge N is visible on q_o after edge N and stays stable until at least edge N+1.
- Reset timing:
  - Asserting rst_i between edges has no effect until the next rising edge.
  - Deasserting rst_i lets the very next edge capture d_i if en_i=1.
  - Reset in the middle of a stream of enabled writes discards the pending write at that edge.
- Power-up: q_o is undefined until the first edge with rst_i=1 or en_i=1. No initial value is relied upon.
- Width handling:
  - d_i is captured bit-exact, with no truncation or extension.
  - RESET_VALUE is applied as an ELEM_WIDTH-bit constant.
- en_i or rst_i at X/Z is not a supported operating condition.
- Elaboration-time check: ELEM_WIDTH < 1 must produce a fatal elaboration error.

Decomposition:
- No shared package is required. The block has no typedefs or enums, and ELEM_WIDTH and RESET_VALUE are instance parameters.
- No sub-module is required. The block is a single always_ff process plus the parameter check.
- Other datapath blocks (register file, pipeline stages) instantiate this module rather than writing raw flops.

Test Plan:
- Reset: hold rst_i=1 for 2 edges with en_i=1, d_i=32'hDEAD_BEEF. Required: q_o=32'h0000_0000 after the first edge and after the second.
- Enabled write: rst_i=0, en_i=1, d_i=32'h1234_5678 at edge N. Required: q_o=32'h1234_5678 after edge N; no change before edge N.
- Hold: after the previous step, set en_i=0 and change d_i to 32'hFFFF_FFFF for 5 edges. Required: q_o stays 32'h1234_5678.
- Reset priority and mid-stream reset:
  - With q_o=32'hA5A5_A5A5, drive rst_i=1, en_i=1, d_i=32'h5A5A_5A5A for one edge. Required: q_o=32'h0.
  - Next edge with rst_i=0, en_i=1, d_i=32'h0000_0001. Required: q_o=32'h0000_0001.
- Non-zero reset value: instance with ELEM_WIDTH=8, RESET_VALUE=8'h3C. Required: q_o=8'h3C after a reset edge; a write of 8'hFF gives q_o=8'hFF on the next edge.
- Random: 1000 cycles of random en_i (0/1) and random d_i, compared against a reference model that updates on en_i at each edge. Required: zero mismatches between q_o and the model.
